fft_frame_gen: RTL and testbench

Parametrised stimulus/frame source for the FFT cores, generalising the fixed 8-point data_gen. It emits frames of N = 2^LAYER complex samples on data_real/data_img, with start/over framing pulses and valid qualification. It adds selectable waveform modes, downstream back-pressure (ready), a programmable inter-frame gap and a frame count limit. It drives fft_N in system benches and on-chip self-test.

---
 rtl/fft_frame_gen_pkg.sv | 23 ++
 rtl/fft_frame_gen_if.sv | 29 ++
 rtl/fft_frame_gen_wave_lut.sv | 35 +++
 rtl/fft_frame_gen.sv | 131 +++++++++++++
 tb/tb_fft_frame_gen.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_gen_pkg.sv
// Shared definitions for the FFT frame generator.
//   state_e : frame generator FSM states
//   mode_e  : waveform select codes (sampled at frame start)
//   DW_DEFAULT : default sample width, real and imaginary each
package fft_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_IMP   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

endpackage

// File: rtl/fft_frame_gen_if.sv
// Frame stream bus between the generator (master) and its consumer (slave).
//   en, mode, ready          : consumer -> generator controls
//   data_real/data_img       : DW-bit two's complement sample
//   valid/start/over         : beat qualifier and frame framing pulses
//   frame_cnt, busy          : status
interface fft_frame_gen_if #(
  parameter int unsigned DW = fft_pkg::DW_DEFAULT
);
  logic          en;
  logic [1:0]    mode;
  logic          ready;
  logic [DW-1:0] data_real;
  logic [DW-1:0] data_img;
  logic          valid;
  logic          start;
  logic          over;
  logic [15:0]   frame_cnt;
  logic          busy;

  modport master (
    input  en, mode, ready,
    output data_real, data_img, valid, start, over, frame_cnt, busy
  );

  modport slave (
    output en, mode, ready,
    input  data_real, data_img, valid, start, over, frame_cnt, busy
  );
endinterface

// File: rtl/fft_frame_gen_wave_lut.sv
// Combinational waveform table: maps (mode, sample index k) to a complex
// sample. Imaginary part is always zero.
//   mode_i : waveform select
//   k_i    : sample index within the frame, unsigned
//   real_o : real part, DW-bit two's complement
//   img_o  : imaginary part
module fft_wave_lut
  import fft_pkg::*;
#(
  parameter int unsigned LAYER = 3,
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned AMP   = 1024
) (
  input  mode_e            mode_i,
  input  logic [LAYER-1:0] k_i,
  output logic [DW-1:0]    real_o,
  output logic [DW-1:0]    img_o
);

  localparam logic [DW-1:0] AMP_V     = DW'(AMP);
  localparam logic [DW-1:0] NEG_AMP_V = (~AMP_V) + DW'(1);

  always_comb begin
    real_o = '0;
    img_o  = '0;
    case (mode_i)
      MODE_RAMP:  real_o = DW'(k_i);
      MODE_IMP:   if (k_i == '0) real_o = AMP_V;
      MODE_CONST: real_o = AMP_V;
      MODE_ALT:   real_o = k_i[0] ? NEG_AMP_V : AMP_V;
      default:    real_o = '0;
    endcase
  end

endmodule

// File: rtl/fft_frame_gen.sv
// Parametrised frame source for the FFT cores. Emits frames of 2^LAYER
// complex samples with start/over framing, honours downstream ready,
// inserts GAP idle cycles between frames and optionally stops after
// FRAMES frames until en is seen low.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : master side of the frame stream interface
module fft_frame_gen
  import fft_pkg::*;
#(
  parameter int unsigned LAYER  = 3,
  parameter int unsigned DW     = DW_DEFAULT,
  parameter int unsigned AMP    = 1024,
  parameter int unsigned GAP    = 2,
  parameter int unsigned FRAMES = 0
) (
  input logic            clk,
  input logic            rst,
  fft_frame_gen_if.master bus
);

  localparam logic [LAYER-1:0] K_LAST   = '1;
  localparam logic [31:0]      GAP_LOAD = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

  state_e           state_q, state_d;
  logic [LAYER-1:0] k_q, k_d;
  mode_e            mode_q, mode_d;
  logic [31:0]      gap_q, gap_d;
  logic [31:0]      sess_q, sess_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [DW-1:0]    lut_real, lut_img;
  logic             run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= MODE_RAMP;
      gap_q   <= '0;
      sess_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
      sess_q  <= sess_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    sess_d  = sess_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Each entry from IDLE is a fresh en session for the frame limit.
        if (bus.en) begin
          state_d = ST_RUN;
          k_d     = '0;
          mode_d  = mode_e'(bus.mode);
          sess_d  = '0;
        end
      end
      ST_RUN: begin
        if (bus.ready) begin
          k_d = k_q + LAYER'(1);
          if (k_q == K_LAST) begin
            k_d    = '0;
            cnt_d  = cnt_q + 16'd1;
            sess_d = sess_q + 32'd1;
            if (!bus.en) begin
              state_d = ST_IDLE;
            end else if ((FRAMES != 0) && (sess_q + 32'd1 == 32'(FRAMES))) begin
              state_d = ST_DONE;
            end else if (GAP != 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              // Back-to-back: the next beat is a start beat, so re-sample mode now.
              mode_d = mode_e'(bus.mode);
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          if (!bus.en) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
            mode_d  = mode_e'(bus.mode);
          end
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      ST_DONE: begin
        if (!bus.en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fft_wave_lut #(
    .LAYER (LAYER),
    .DW    (DW),
    .AMP   (AMP)
  ) u_lut (
    .mode_i (mode_q),
    .k_i    (k_q),
    .real_o (lut_real),
    .img_o  (lut_img)
  );

  // Outputs decode straight from registered state so reset clears them
  // without waiting for a clock edge.
  assign run           = (state_q == ST_RUN);
  assign bus.valid     = run;
  assign bus.start     = run && (k_q == '0);
  assign bus.over      = run && (k_q == K_LAST);
  assign bus.data_real = run ? lut_real : '0;
  assign bus.data_img  = run ? lut_img : '0;
  assign bus.frame_cnt = cnt_q;
  assign bus.busy      = run || (state_q == ST_GAP);

endmodule

// File: tb/tb_fft_frame_gen.sv
// Self-checking bench: two generator instances (continuous with GAP=2, and
// FRAMES=2 with GAP=0) checked every cycle against a behavioural model.
module tb_fft_frame_gen;

  localparam int N   = 8;
  localparam int AMP = 1024;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  fft_frame_gen_if #(.DW(32)) ia ();
  fft_frame_gen_if #(.DW(32)) ib ();

  fft_frame_gen #(.LAYER(3), .DW(32), .AMP(AMP), .GAP(2), .FRAMES(0)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ia)
  );
  fft_frame_gen #(.LAYER(3), .DW(32), .AMP(AMP), .GAP(0), .FRAMES(2)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ib)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model per instance: frame position, pending gap cycles, limit stop.
  int gap_p[2]    = '{2, 0};
  int frames_p[2] = '{0, 2};
  bit m_in[2];
  int m_k[2];
  int m_gap[2];
  bit m_stop[2];
  int m_sess[2];
  int m_cnt[2];
  int m_mode[2];
  int beats[2];

  function automatic logic [31:0] ref_real(input int md, input int k);
    int v;
    case (md)
      0:       v = k;
      1:       v = (k == 0) ? AMP : 0;
      2:       v = AMP;
      default: v = (k % 2 == 0) ? AMP : -AMP;
    endcase
    return 32'(v);
  endfunction

  task automatic model_reset(input int w);
    m_in[w] = 0; m_k[w] = 0; m_gap[w] = -1; m_stop[w] = 0;
    m_sess[w] = 0; m_cnt[w] = 0; m_mode[w] = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input int w, input bit e, input int md, input bit rdy);
    if (m_in[w]) begin
      if (rdy) begin
        m_k[w]++;
        if (m_k[w] == N) begin
          m_k[w] = 0;
          m_cnt[w]++;
          m_sess[w]++;
          if (!e) m_in[w] = 0;
          else if (frames_p[w] > 0 && m_sess[w] == frames_p[w]) begin
            m_in[w] = 0; m_stop[w] = 1;
          end else if (gap_p[w] > 0) begin
            m_in[w] = 0; m_gap[w] = gap_p[w];
          end else m_mode[w] = md;
        end
      end
    end else if (m_stop[w]) begin
      if (!e) m_stop[w] = 0;
    end else if (m_gap[w] > 0) begin
      m_gap[w]--;
      if (m_gap[w] == 0) begin
        m_gap[w] = -1;
        if (e) begin m_in[w] = 1; m_k[w] = 0; m_mode[w] = md; end
      end
    end else if (e) begin
      m_in[w] = 1; m_k[w] = 0; m_mode[w] = md; m_sess[w] = 0;
    end
  endtask

  task automatic check(input int w, input string tag);
    logic [83:0] obs, exp;
    if (w == 0)
      obs = {ia.valid, ia.start, ia.over, ia.busy, ia.frame_cnt, ia.data_real, ia.data_img};
    else
      obs = {ib.valid, ib.start, ib.over, ib.busy, ib.frame_cnt, ib.data_real, ib.data_img};
    exp = {m_in[w], m_in[w] && (m_k[w] == 0), m_in[w] && (m_k[w] == N - 1),
           m_in[w] || (m_gap[w] > 0), 16'(m_cnt[w]),
           m_in[w] ? ref_real(m_mode[w], m_k[w]) : 32'h0, 32'h0};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, w, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, cross one rising edge, check.
  task automatic step(input int w, input bit e, input int md, input bit rdy, input string tag);
    if (w == 0) begin
      if (ia.valid && rdy) beats[0]++;
      ia.en = e; ia.mode = 2'(md); ia.ready = rdy;
    end else begin
      if (ib.valid && rdy) beats[1]++;
      ib.en = e; ib.mode = 2'(md); ib.ready = rdy;
    end
    model_edge(w, e, md, rdy);
    @(posedge clk);
    @(negedge clk);
    check(w, tag);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ia.en = 1'b0; ia.mode = 2'd0; ia.ready = 1'b0;
    ib.en = 1'b0; ib.mode = 2'd0; ib.ready = 1'b0;
    beats = '{0, 0};
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    @(negedge clk);
    check(0, "reset");
    check(1, "reset");
    rst_a = 1'b1; rst_b = 1'b1;

    // Ramp frames, continuous ready, GAP=2.
    for (int i = 0; i < 30; i++) step(0, 1, 0, 1, "ramp");
    // Alternating +/-AMP.
    for (int i = 0; i < 20; i++) step(0, 1, 3, 1, "alt");

    // Stall pattern 1,0,0,1 in the middle of a ramp frame.
    for (int i = 0; i < 40 && !(m_in[0] && m_k[0] == 2 && m_mode[0] == 0); i++)
      step(0, 1, 0, 1, "seek_k2");
    check_int("reach_k2", int'(m_in[0] && m_k[0] == 2 && m_mode[0] == 0), 1);
    step(0, 1, 0, 1, "stall");
    step(0, 1, 0, 0, "stall");
    step(0, 1, 0, 0, "stall");
    step(0, 1, 0, 1, "stall");
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, "stall_tail");

    // Randomised ready, mode and occasional en drops.
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 15) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0, "rand");

    // en falls at k=3, mode switches to impulse at k=4.
    for (int i = 0; i < 60 && !(m_in[0] && m_k[0] == 3 && m_mode[0] == 0); i++)
      step(0, 1, 0, 1, "seek_k3");
    check_int("reach_k3", int'(m_in[0] && m_k[0] == 3 && m_mode[0] == 0), 1);
    step(0, 0, 0, 1, "en_drop");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, "en_drop");
    check_int("idle_after_drop", int'(ia.valid), 0);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 1, "impulse");

    // Asynchronous reset at k=5.
    for (int i = 0; i < 40 && !(m_in[0] && m_k[0] == 5); i++) step(0, 1, 0, 1, "seek_k5");
    check_int("reach_k5", int'(m_in[0] && m_k[0] == 5), 1);
    #1 rst_a = 1'b0;
    model_reset(0);
    #1 check(0, "async_rst");
    @(posedge clk);
    @(negedge clk);
    check(0, "rst_hold");
    rst_a = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, "post_rst");
    step(0, 0, 0, 1, "a_quiesce");

    // Frame limit: FRAMES=2, GAP=0.
    beats[1] = 0;
    for (int i = 0; i < 24; i++) step(1, 1, 0, 1, "limit");
    check_int("limit_beats", beats[1], 16);
    step(1, 0, 0, 1, "limit_release");
    step(1, 0, 0, 1, "limit_release");
    beats[1] = 0;
    for (int i = 0; i < 24; i++) step(1, 1, 2, 1, "limit2");
    check_int("limit2_beats", beats[1], 16);
    check_int("limit2_cnt", int'(ib.frame_cnt), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
